// File: rtl/mux_pkg.sv
// Shared definitions for the registered channel selector: mode encoding and
// channel-count helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int chan_count(input int sel_bits);
    return 1 << sel_bits;
  endfunction

endpackage : mux_pkg

// File: rtl/mux_sel_stream_rr_pick.sv
// Combinational round-robin picker: first valid channel scanning upward from
// ptr, wrapping modulo the channel count.
module rr_pick
  import mux_pkg::*;
#(
  parameter int SEL_BITS = 3
) (
  input  logic [chan_count(SEL_BITS)-1:0] in_valid,
  input  logic [SEL_BITS-1:0]             ptr,
  output logic                            found,
  output logic [SEL_BITS-1:0]             candidate
);

  localparam int N = chan_count(SEL_BITS);

  // Channel index reached at each scan offset; SEL_BITS-wide addition wraps.
  logic [SEL_BITS-1:0] scan_idx [N];
  logic [N-1:0]        scan_hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_scan
    assign scan_idx[gi] = ptr + SEL_BITS'(gi);
    assign scan_hit[gi] = in_valid[scan_idx[gi]];
  end

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found     = 1'b0;
    candidate = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (scan_hit[k]) begin
        found     = 1'b1;
        candidate = scan_idx[k];
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux_sel_stream.sv
// N-way channel selector with fixed or round-robin selection feeding a
// one-entry valid/ready output register.
module mux_sel_stream
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SEL_BITS = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [chan_count(SEL_BITS)*WIDTH-1:0] in_data,
  input  logic [chan_count(SEL_BITS)-1:0]       in_valid,
  output logic [chan_count(SEL_BITS)-1:0]       in_ready,
  input  logic [SEL_BITS-1:0]                   sel,
  input  logic                                  rr_en,
  output logic [WIDTH-1:0]                      out_data,
  output logic [SEL_BITS-1:0]                   out_chan,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int N = chan_count(SEL_BITS);

  logic [WIDTH-1:0]    chan_data [N];
  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_BITS-1:0] out_chan_reg;
  logic                out_valid_reg;
  logic [SEL_BITS-1:0] ptr_reg;
  logic [SEL_BITS-1:0] ptr_next;

  logic                rr_found;
  logic [SEL_BITS-1:0] rr_cand;
  logic [SEL_BITS-1:0] candidate;
  logic                grant;
  logic                space;
  logic                accept;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .SEL_BITS (SEL_BITS)
  ) u_rr_pick (
    .in_valid  (in_valid),
    .ptr       (ptr_reg),
    .found     (rr_found),
    .candidate (rr_cand)
  );

  always_comb begin
    if (rr_en == MODE_RR) begin
      candidate = rr_cand;
      grant     = rr_found;
    end else begin
      candidate = sel;
      grant     = in_valid[sel];
    end
  end

  // Reset gates acceptance so nothing is handshaken during a reset cycle.
  assign space    = !out_valid_reg || out_ready;
  assign accept   = space && grant && !rst;
  assign ptr_next = candidate + SEL_BITS'(1);

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[candidate] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (accept) begin
      out_data_reg  <= chan_data[candidate];
      out_chan_reg  <= candidate;
      out_valid_reg <= 1'b1;
      if (rr_en == MODE_RR) begin
        ptr_reg <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

endmodule : mux_sel_stream
